// File: rtl/data_path.sv
// Bus-based 32-bit processor datapath: register file, special registers, ALU with 64-bit Z and branch condition.
// Optional feature macro: DATAPATH_MULDIV_EN builds the signed multiplier and divider.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InPort,
  input  logic [4:0]  ops,
  input  logic R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic RAout,  input logic RYout,  input logic RZHIout, input logic RZLOout,
  input  logic PCout,  input logic IRout,  input logic HIout,   input logic LOout,
  input  logic MDRout, input logic MARout, input logic InPortOut, input logic cout,
  input  logic BAout,  input logic rout,
  input  logic R0in,   input logic R1in,   input logic R2in,   input logic R3in,
  input  logic R4in,   input logic R5in,   input logic R6in,   input logic R7in,
  input  logic R8in,   input logic R9in,   input logic R10in,  input logic R11in,
  input  logic R12in,  input logic R13in,  input logic R14in,  input logic R15in,
  input  logic RAin,   input logic RYin,   input logic RZin,   input logic PCin,
  input  logic IRin,   input logic HIin,   input logic LOin,   input logic MDRin,
  input  logic MARin,  input logic PORTin, input logic rin,    input logic conin,
  input  logic Read,   input logic Write,  input logic IncPC,
  input  logic gra,    input logic grb,    input logic grc,
  output logic [31:0] MARq,
  output logic [31:0] MDRq,
  output logic        MemWrite,
  output logic [31:0] OutPort,
  output logic        CON,
  output logic [31:0] BusMux
);

  logic [31:0] gpr_q [16];
  logic [31:0] ra_q, y_q, pc_q, ir_q, hi_q, lo_q, mdr_q, mar_q, outport_q;
  logic [63:0] z_q;
  logic        con_q;

  logic [15:0] regOut, regIn;
  logic [3:0]  sel;
  logic [31:0] selVal, cSext, mdr_d;
  logic [63:0] z_d;
  logic        con_d;
  logic [4:0]  shamt;
  logic [31:0] sra;

  assign regOut = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign regIn  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  always_comb begin
    sel = 4'd0;
    if (gra)      sel = ir_q[26:23];
    else if (grb) sel = ir_q[22:19];
    else if (grc) sel = ir_q[18:15];
  end

  assign selVal = gpr_q[sel];
  assign cSext  = {{13{ir_q[18]}}, ir_q[18:0]};

  // Lowest-priority source is written first so higher-priority drivers overwrite it.
  always_comb begin
    BusMux = 32'd0;
    if (cout)      BusMux = cSext;
    if (InPortOut) BusMux = InPort;
    if (MARout)    BusMux = mar_q;
    if (MDRout)    BusMux = mdr_q;
    if (LOout)     BusMux = lo_q;
    if (HIout)     BusMux = hi_q;
    if (IRout)     BusMux = ir_q;
    if (PCout)     BusMux = pc_q;
    if (RZLOout)   BusMux = z_q[31:0];
    if (RZHIout)   BusMux = z_q[63:32];
    if (RYout)     BusMux = y_q;
    if (BAout)     BusMux = (sel == 4'd0) ? 32'd0 : selVal;
    if (rout)      BusMux = selVal;
    if (RAout)     BusMux = ra_q;
    for (int i = 15; i >= 0; i--) begin
      if (regOut[i]) BusMux = gpr_q[i];
    end
  end

  assign shamt = BusMux[4:0];
  assign sra   = $signed(y_q) >>> shamt;

`ifdef DATAPATH_MULDIV_EN
  logic [63:0] product;
  logic [31:0] divisor, quot, rem;
  assign product = {{32{y_q[31]}}, y_q} * {{32{BusMux[31]}}, BusMux};
  assign divisor = (BusMux == 32'd0) ? 32'd1 : BusMux;
  assign quot    = $signed(y_q) / $signed(divisor);
  assign rem     = $signed(y_q) % $signed(divisor);
`endif

  always_comb begin
    z_d = 64'd0;
    case (ops)
      5'b00011: z_d = {32'd0, y_q + BusMux};
      5'b00100: z_d = {32'd0, y_q - BusMux};
      5'b00101: z_d = {32'd0, y_q & BusMux};
      5'b00110: z_d = {32'd0, y_q | BusMux};
      5'b00111: z_d = {32'd0, y_q >> shamt};
      5'b01000: z_d = {32'd0, sra};
      5'b01001: z_d = {32'd0, y_q << shamt};
      5'b01010: z_d = {32'd0, (y_q >> shamt) | (y_q << (6'd32 - {1'b0, shamt}))};
      5'b01011: z_d = {32'd0, (y_q << shamt) | (y_q >> (6'd32 - {1'b0, shamt}))};
      5'b01100: z_d = {32'd0, 32'd0 - BusMux};
      5'b01101: z_d = {32'd0, ~BusMux};
`ifdef DATAPATH_MULDIV_EN
      5'b01110: z_d = product;
      5'b01111: z_d = (BusMux == 32'd0) ? 64'd0 : {rem, quot};
`endif
      default:  z_d = 64'd0;
    endcase
    if (IncPC) z_d = {32'd0, BusMux + 32'd1};
  end

  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00: con_d = (BusMux == 32'd0);
      2'b01: con_d = (BusMux != 32'd0);
      2'b10: con_d = !BusMux[31] && (BusMux != 32'd0);
      2'b11: con_d = BusMux[31];
      default: con_d = 1'b0;
    endcase
  end

  assign mdr_d = Read ? Mdatain : BusMux;

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) gpr_q[i] <= 32'd0;
      ra_q <= 32'd0;  y_q <= 32'd0;  pc_q <= 32'd0;  ir_q <= 32'd0;
      hi_q <= 32'd0;  lo_q <= 32'd0; mdr_q <= 32'd0; mar_q <= 32'd0;
      outport_q <= 32'd0;
      z_q <= 64'd0;
      con_q <= 1'b0;
    end else begin
      // Named enables and the IR-selected rin write can target the same register; both load the bus.
      for (int i = 0; i < 16; i++) begin
        if (regIn[i] || (rin && (sel == i[3:0]))) gpr_q[i] <= BusMux;
      end
      if (RAin)   ra_q      <= BusMux;
      if (RYin)   y_q       <= BusMux;
      if (PCin)   pc_q      <= BusMux;
      if (IRin)   ir_q      <= BusMux;
      if (HIin)   hi_q      <= BusMux;
      if (LOin)   lo_q      <= BusMux;
      if (MDRin)  mdr_q     <= mdr_d;
      if (MARin)  mar_q     <= BusMux;
      if (PORTin) outport_q <= BusMux;
      if (RZin)   z_q       <= z_d;
      if (conin)  con_q     <= con_d;
    end
  end

  assign MARq     = mar_q;
  assign MDRq     = mdr_q;
  assign MemWrite = Write;
  assign OutPort  = outport_q;
  assign CON      = con_q;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected observations, a negedge monitor pops and compares.
module tb_data_path;

  localparam int K_BUS = 0, K_MAR = 1, K_MDR = 2, K_CON = 3, K_OUT = 4, K_MW = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain, InPort;
  logic [4:0]  ops;
  logic [15:0] rOut, rIn;
  logic RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout;
  logic MDRout, MARout, InPortOut, cout, BAout, rout;
  logic RAin, RYin, RZin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin, rin, conin;
  logic Read, Write, IncPC, gra, grb, grc;
  logic [31:0] MARq, MDRq, OutPort, BusMux;
  logic        MemWrite, CON;

  exp_t sbQ[$];
  logic obs = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .InPort(InPort), .ops(ops),
    .R0out(rOut[0]), .R1out(rOut[1]), .R2out(rOut[2]), .R3out(rOut[3]),
    .R4out(rOut[4]), .R5out(rOut[5]), .R6out(rOut[6]), .R7out(rOut[7]),
    .R8out(rOut[8]), .R9out(rOut[9]), .R10out(rOut[10]), .R11out(rOut[11]),
    .R12out(rOut[12]), .R13out(rOut[13]), .R14out(rOut[14]), .R15out(rOut[15]),
    .RAout(RAout), .RYout(RYout), .RZHIout(RZHIout), .RZLOout(RZLOout),
    .PCout(PCout), .IRout(IRout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .MARout(MARout), .InPortOut(InPortOut), .cout(cout),
    .BAout(BAout), .rout(rout),
    .R0in(rIn[0]), .R1in(rIn[1]), .R2in(rIn[2]), .R3in(rIn[3]),
    .R4in(rIn[4]), .R5in(rIn[5]), .R6in(rIn[6]), .R7in(rIn[7]),
    .R8in(rIn[8]), .R9in(rIn[9]), .R10in(rIn[10]), .R11in(rIn[11]),
    .R12in(rIn[12]), .R13in(rIn[13]), .R14in(rIn[14]), .R15in(rIn[15]),
    .RAin(RAin), .RYin(RYin), .RZin(RZin), .PCin(PCin), .IRin(IRin),
    .HIin(HIin), .LOin(LOin), .MDRin(MDRin), .MARin(MARin), .PORTin(PORTin),
    .rin(rin), .conin(conin), .Read(Read), .Write(Write), .IncPC(IncPC),
    .gra(gra), .grb(grb), .grc(grc),
    .MARq(MARq), .MDRq(MDRq), .MemWrite(MemWrite), .OutPort(OutPort),
    .CON(CON), .BusMux(BusMux)
  );

  function automatic logic [31:0] actualOf(int kind);
    case (kind)
      K_MAR:   return MARq;
      K_MDR:   return MDRq;
      K_CON:   return {31'd0, CON};
      K_OUT:   return OutPort;
      K_MW:    return {31'd0, MemWrite};
      default: return BusMux;
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    if (obs) begin
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpectedObserve actual=%h expected=<none>", BusMux);
      end else begin
        e   = sbQ.pop_front();
        act = actualOf(e.kind);
        if (act !== e.val) begin
          failures++;
          $display("[TB] FAIL %s actual=%h expected=%h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic clearCtl();
    ops = 5'd0; rOut = 16'd0; rIn = 16'd0;
    RAout = 0; RYout = 0; RZHIout = 0; RZLOout = 0; PCout = 0; IRout = 0; HIout = 0; LOout = 0;
    MDRout = 0; MARout = 0; InPortOut = 0; cout = 0; BAout = 0; rout = 0;
    RAin = 0; RYin = 0; RZin = 0; PCin = 0; IRin = 0; HIin = 0; LOin = 0; MDRin = 0;
    MARin = 0; PORTin = 0; rin = 0; conin = 0;
    Read = 0; Write = 0; IncPC = 0; gra = 0; grb = 0; grc = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setBus(logic [31:0] v);
    InPort = v;
    InPortOut = 1'b1;
  endtask

  // Queue the expectation, then hold the current controls across one negedge sample and one edge.
  task automatic checkOutput(string name, int kind, logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    sbQ.push_back(e);
    obs = 1'b1;
    step();
    obs = 1'b0;
    clearCtl();
  endtask

  task automatic aluOp(string name, logic [31:0] a, logic [31:0] b, logic [4:0] op,
                       logic inc, logic [31:0] lo, logic [31:0] hi);
    clearCtl(); setBus(a); RYin = 1; step(); clearCtl();
    setBus(b); ops = op; IncPC = inc; RZin = 1; step(); clearCtl();
    RZLOout = 1; checkOutput({name, "Lo"}, K_BUS, lo);
    RZHIout = 1; checkOutput({name, "Hi"}, K_BUS, hi);
  endtask

  task automatic branchCase(string name, logic [31:0] irVal, logic [31:0] r3Val, logic expCon);
    setBus(irVal); IRin = 1; step(); clearCtl();
    setBus(r3Val); rIn[3] = 1; step(); clearCtl();
    gra = 1; rout = 1; conin = 1; checkOutput({name, "Bus"}, K_BUS, r3Val);
    checkOutput({name, "Con"}, K_CON, {31'd0, expCon});
  endtask

  task automatic applyStimulus();
    clearCtl(); clear = 0; Mdatain = 0; InPort = 0;
    step(); step(); clear = 1;
    rOut[5] = 1;  checkOutput("rstR5", K_BUS, 32'd0);
    RZHIout = 1;  checkOutput("rstZhi", K_BUS, 32'd0);
    checkOutput("rstMAR", K_MAR, 32'd0);
    checkOutput("rstCON", K_CON, 32'd0);
    checkOutput("rstOutPort", K_OUT, 32'd0);
    checkOutput("busIdle", K_BUS, 32'd0);

    // Instruction fetch
    setBus(32'd5); PCin = 1; step(); clearCtl();
    PCout = 1; MARin = 1; IncPC = 1; RZin = 1; checkOutput("fetchBusPC", K_BUS, 32'd5);
    RZLOout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h9A980023; step(); clearCtl();
    MDRout = 1; IRin = 1; step(); clearCtl();
    checkOutput("fetchMAR", K_MAR, 32'd5);
    checkOutput("fetchMDR", K_MDR, 32'h9A980023);
    PCout = 1; checkOutput("fetchPC", K_BUS, 32'd6);
    IRout = 1; checkOutput("fetchIR", K_BUS, 32'h9A980023);
    setBus(32'h1111); MDRin = 1; step(); clearCtl();
    checkOutput("mdrFromBus", K_MDR, 32'h1111);
    Write = 1; checkOutput("memWriteHi", K_MW, 32'd1);
    checkOutput("memWriteLo", K_MW, 32'd0);

    branchCase("brNz1",  32'h01880000, 32'd7, 1'b1);
    branchCase("brNz0",  32'h01880000, 32'd0, 1'b0);
    branchCase("brZero", 32'h01800000, 32'd0, 1'b1);
    branchCase("brPosN", 32'h01900000, 32'h80000000, 1'b0);
    branchCase("brPos",  32'h01900000, 32'd1, 1'b1);
    branchCase("brNeg",  32'h01980000, 32'h80000000, 1'b1);

    // Branch offset: PC (still 6) plus sign-extended C of -1
    PCout = 1; RYin = 1; step(); clearCtl();
    setBus(32'h0007FFFF); IRin = 1; step(); clearCtl();
    cout = 1; checkOutput("coutSext", K_BUS, 32'hFFFFFFFF);
    cout = 1; ops = 5'b00011; RZin = 1; step(); clearCtl();
    RZLOout = 1; checkOutput("offsetLo", K_BUS, 32'd5);
    RZHIout = 1; checkOutput("offsetHi", K_BUS, 32'd0);

    setBus(32'h55); rIn[0] = 1; step(); clearCtl();
    setBus(32'h0); IRin = 1; step(); clearCtl();
    grb = 1; BAout = 1; checkOutput("baR0", K_BUS, 32'd0);
    grb = 1; rout = 1;  checkOutput("routR0", K_BUS, 32'h55);
    setBus(32'h00100000); IRin = 1; step(); clearCtl();
    setBus(32'h55); rIn[2] = 1; step(); clearCtl();
    grb = 1; BAout = 1; checkOutput("baR2", K_BUS, 32'h55);
    setBus(32'hABCD); grb = 1; rin = 1; step(); clearCtl();
    rOut[2] = 1; checkOutput("rinR2", K_BUS, 32'hABCD);
    setBus(32'h11); rIn[1] = 1; step(); clearCtl();
    rOut[1] = 1; rOut[2] = 1; PCout = 1; checkOutput("busPriority", K_BUS, 32'h11);

    setBus(32'hAAAA0001); HIin = 1; step(); clearCtl();
    setBus(32'h0000BEEF); LOin = 1; step(); clearCtl();
    HIout = 1; checkOutput("hiReg", K_BUS, 32'hAAAA0001);
    LOout = 1; checkOutput("loReg", K_BUS, 32'h0000BEEF);
    setBus(32'hCAFE); PORTin = 1; step(); clearCtl();
    checkOutput("outPort", K_OUT, 32'hCAFE);
    setBus(32'h77); RAin = 1; step(); clearCtl();
    RAout = 1; checkOutput("raReg", K_BUS, 32'h77);

    aluOp("add",     32'hFFFFFFFF, 32'd2, 5'b00011, 1'b0, 32'd1, 32'd0);
    aluOp("sub",     32'd3, 32'd5, 5'b00100, 1'b0, 32'hFFFFFFFE, 32'd0);
    aluOp("and",     32'hF0F0, 32'hFF00, 5'b00101, 1'b0, 32'hF000, 32'd0);
    aluOp("or",      32'hF0F0, 32'h0F0F, 5'b00110, 1'b0, 32'hFFFF, 32'd0);
    aluOp("shr",     32'h80000000, 32'd4, 5'b00111, 1'b0, 32'h08000000, 32'd0);
    aluOp("shra",    32'h80000000, 32'd4, 5'b01000, 1'b0, 32'hF8000000, 32'd0);
    aluOp("shl",     32'd1, 32'd31, 5'b01001, 1'b0, 32'h80000000, 32'd0);
    aluOp("shlWrap", 32'd1, 32'd33, 5'b01001, 1'b0, 32'd2, 32'd0);
    aluOp("ror",     32'h12345678, 32'd8, 5'b01010, 1'b0, 32'h78123456, 32'd0);
    aluOp("rol",     32'h12345678, 32'd4, 5'b01011, 1'b0, 32'h23456781, 32'd0);
    aluOp("neg",     32'd0, 32'd5, 5'b01100, 1'b0, 32'hFFFFFFFB, 32'd0);
    aluOp("not",     32'd0, 32'd0, 5'b01101, 1'b0, 32'hFFFFFFFF, 32'd0);
    aluOp("opNone",  32'd5, 32'd6, 5'b00000, 1'b0, 32'd0, 32'd0);
    aluOp("opHigh",  32'd5, 32'd6, 5'b10000, 1'b0, 32'd0, 32'd0);
    aluOp("incPC",   32'd100, 32'd7, 5'b00011, 1'b1, 32'd8, 32'd0);
`ifdef DATAPATH_MULDIV_EN
    aluOp("mul",     32'hFFFFFFFE, 32'd3, 5'b01110, 1'b0, 32'hFFFFFFFA, 32'hFFFFFFFF);
    aluOp("div",     32'd7, 32'd2, 5'b01111, 1'b0, 32'd3, 32'd1);
    aluOp("divNeg",  32'hFFFFFFF9, 32'd2, 5'b01111, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF);
`else
    aluOp("mul",     32'hFFFFFFFE, 32'd3, 5'b01110, 1'b0, 32'd0, 32'd0);
    aluOp("div",     32'd7, 32'd2, 5'b01111, 1'b0, 32'd0, 32'd0);
`endif
    aluOp("divZero", 32'd7, 32'd0, 5'b01111, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of a populated state
    setBus(32'h1234); rIn[5] = 1; step(); clearCtl();
    setBus(32'd1); RYin = 1; step(); clearCtl();
    setBus(32'd1); ops = 5'b00011; RZin = 1; step(); clearCtl();
    setBus(32'h00080000); IRin = 1; step(); clearCtl();
    setBus(32'd1); conin = 1; step(); clearCtl();
    checkOutput("preRstCon", K_CON, 32'd1);
    rOut[5] = 1; checkOutput("preRstR5", K_BUS, 32'h1234);
    RZLOout = 1; checkOutput("preRstZ", K_BUS, 32'd2);
    clear = 0; step(); clear = 1;
    rOut[5] = 1;  checkOutput("postRstR5", K_BUS, 32'd0);
    RZLOout = 1;  checkOutput("postRstZ", K_BUS, 32'd0);
    checkOutput("postRstCon", K_CON, 32'd0);
    checkOutput("postRstMAR", K_MAR, 32'd0);
    checkOutput("postRstOut", K_OUT, 32'd0);
    PCout = 1;    checkOutput("postRstPC", K_BUS, 32'd0);
    setBus(32'h1234); rIn[5] = 1; clear = 0; step(); clear = 1; clearCtl();
    rOut[5] = 1;  checkOutput("rstOverLoad", K_BUS, 32'd0);
  endtask

  initial begin
    applyStimulus();
    repeat (4) @(negedge clock);
    if (sbQ.size() != 0) begin
      failures += sbQ.size();
      $display("[TB] FAIL scoreboardDrain actual=%0d expected=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
